// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch stage.
// Owns the program counter and issues one outstanding instruction-memory
// request at a time. It loads the IF/ID register and holds one response in a
// skid buffer while decode is stalled. Redirects arrive via flush/pc_right.
// Optional feature macro: FETCH_PRED_JAL_EN. When it is defined, a JAL in the
// fetched word steers the next fetch to its target (static taken prediction).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | one cycle after reset, no request yet
// WAIT  | request to pc_q (or to the stale address while dropping) open
// FULL  | skid holds a response that decode could not accept; no request
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] pc_right,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic [31:0] if_next_pc,
    output logic        if_pred_taken
);

    typedef enum logic [1:0] {IDLE, WAIT, FULL} state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    // address of the abandoned transaction, kept on the bus until it completes
    logic [31:0] stale_q, stale_d;

    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_next_q, skid_next_d;
    logic        skid_pred_q, skid_pred_d;

    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [31:0] if_next_q, if_next_d;
    logic        if_pred_q, if_pred_d;

    logic [31:0] fetch_next;
    logic        fetch_pred;

    // redirect targets are forced word-aligned, so the low bits are ignored
    logic        pc_right_unused;
    assign pc_right_unused = ^pc_right[1:0];

`ifdef FETCH_PRED_JAL_EN
    logic [31:0] jal_imm;

    // fall-through or predicted JAL target of the word being returned now
    always_comb begin
        jal_imm    = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                      imem_rdata[20], imem_rdata[30:21], 1'b0};
        fetch_pred = (imem_rdata[6:0] == 7'b1101111);
        fetch_next = pc_q + (fetch_pred ? jal_imm : 32'd4);
    end
`else
    assign fetch_pred = 1'b0;
    assign fetch_next = pc_q + 32'd4;
`endif

    // request is purely state-driven; the address never depends on imem_rdata
    assign imem_req      = (state_q == WAIT);
    assign imem_addr     = drop_q ? stale_q : pc_q;
    assign if_valid      = if_valid_q;
    assign if_pc         = if_pc_q;
    assign if_inst       = if_inst_q;
    assign if_next_pc    = if_next_q;
    assign if_pred_taken = if_pred_q;

    // next-state, PC, skid and IF/ID update; flush overrides stall and responses
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        stale_d     = stale_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        skid_next_d = skid_next_q;
        skid_pred_d = skid_pred_q;
        if_valid_d  = if_valid_q;
        if_pc_d     = if_pc_q;
        if_inst_d   = if_inst_q;
        if_next_d   = if_next_q;
        if_pred_d   = if_pred_q;

        if (flush) begin
            if_valid_d = 1'b0;
            pc_d       = {pc_right[31:2], 2'b00};
            case (state_q)
                IDLE: state_d = WAIT;
                WAIT: begin
                    if (imem_valid) begin
                        drop_d = 1'b0;
                    end else begin
                        // a second flush while dropping keeps the original address
                        if (!drop_q) stale_d = pc_q;
                        drop_d = 1'b1;
                    end
                end
                FULL:    state_d = WAIT;
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT;
                    if (!stall) if_valid_d = 1'b0;
                end
                WAIT: begin
                    if (imem_valid && drop_q) begin
                        drop_d = 1'b0;
                        if (!stall) if_valid_d = 1'b0;
                    end else if (imem_valid && (!if_valid_q || !stall)) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_q;
                        if_inst_d  = imem_rdata;
                        if_next_d  = fetch_next;
                        if_pred_d  = fetch_pred;
                        pc_d       = fetch_next;
                    end else if (imem_valid) begin
                        skid_pc_d   = pc_q;
                        skid_inst_d = imem_rdata;
                        skid_next_d = fetch_next;
                        skid_pred_d = fetch_pred;
                        pc_d        = fetch_next;
                        state_d     = FULL;
                    end else if (!stall) begin
                        if_valid_d = 1'b0;
                    end
                end
                FULL: begin
                    if (!stall) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = skid_pc_q;
                        if_inst_d  = skid_inst_q;
                        if_next_d  = skid_next_q;
                        if_pred_d  = skid_pred_q;
                        state_d    = WAIT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // state and datapath registers; reset abandons any open transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            stale_q     <= 32'h0;
            skid_pc_q   <= 32'h0;
            skid_inst_q <= NOP_INST;
            skid_next_q <= 32'h0;
            skid_pred_q <= 1'b0;
            if_valid_q  <= 1'b0;
            if_pc_q     <= 32'h0;
            if_inst_q   <= NOP_INST;
            if_next_q   <= 32'h0;
            if_pred_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            stale_q     <= stale_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
            skid_next_q <= skid_next_d;
            skid_pred_q <= skid_pred_d;
            if_valid_q  <= if_valid_d;
            if_pc_q     <= if_pc_d;
            if_inst_q   <= if_inst_d;
            if_next_q   <= if_next_d;
            if_pred_q   <= if_pred_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed test-plan sequence, then random stall /
// flush / memory latency / reset traffic checked against a transaction model.
module tb_fetch_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] pc_right;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [31:0] if_next_pc;
    logic        if_pred_taken;

    int n_cmp = 0;
    int n_err = 0;

    fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .pc_right      (pc_right),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_next_pc    (if_next_pc),
        .if_pred_taken (if_pred_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // instruction memory contents: NOPs low, a JAL(+0x40) at 0x20, hashed words elsewhere
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        logic [20:0] imm;
        if (a < 32'h20 || a == 32'hFFFF_FFFC) return 32'h0000_0013;
        if (a == 32'h20) begin
            imm = 21'h40;
        end else begin
            h = (a ^ 32'h5bd1_e995) * 32'h9E37_79B1;
            if (h[31:29] != 3'b000) return {h[24:0], 7'h13};
            imm = {{9{h[13]}}, h[13:3], 1'b0};
        end
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] next;
        logic        pred;
    } fetch_t;

    bit          m_started;
    logic [31:0] m_pc;
    bit          m_stale;
    logic [31:0] m_stale_addr;
    fetch_t      m_skid[$];
    bit          m_ifv;
    fetch_t      m_ifid;

    function automatic fetch_t make_fetch(input logic [31:0] pc, input logic [31:0] inst);
        fetch_t f;
        f.pc   = pc;
        f.inst = inst;
        f.next = pc + 32'd4;
        f.pred = 1'b0;
`ifdef FETCH_PRED_JAL_EN
        if (inst[6:0] == 7'b1101111) begin
            int imm;
            imm = (inst[31] ? -1048576 : 0)
                + (int'({24'b0, inst[19:12]}) << 12)
                + (int'({31'b0, inst[20]}) << 11)
                + (int'({22'b0, inst[30:21]}) << 1);
            f.next = pc + 32'(imm);
            f.pred = 1'b1;
        end
`endif
        return f;
    endfunction

    task automatic model_reset();
        m_started    = 1'b0;
        m_pc         = RST_PC;
        m_stale      = 1'b0;
        m_stale_addr = 32'h0;
        m_skid.delete();
        m_ifv        = 1'b0;
        m_ifid       = '{pc: 32'h0, inst: 32'h13, next: 32'h0, pred: 1'b0};
    endtask

    function automatic bit m_req();
        return m_started && (m_skid.size() == 0);
    endfunction

    function automatic logic [31:0] m_addr();
        return m_stale ? m_stale_addr : m_pc;
    endfunction

    task automatic model_step(input bit st, input bit fl, input logic [31:0] pr,
                              input bit v, input logic [31:0] rd);
        fetch_t f;
        if (!m_started) begin
            m_started = 1'b1;
            if (fl) begin
                m_pc  = {pr[31:2], 2'b00};
                m_ifv = 1'b0;
            end
        end else if (fl) begin
            m_ifv = 1'b0;
            if (m_req() && !v) begin
                if (!m_stale) m_stale_addr = m_pc;
                m_stale = 1'b1;
            end else if (v) begin
                m_stale = 1'b0;
            end
            m_skid.delete();
            m_pc = {pr[31:2], 2'b00};
        end else if (m_skid.size() != 0) begin
            if (!st) begin
                m_ifid = m_skid.pop_front();
                m_ifv  = 1'b1;
            end
        end else if (v) begin
            if (m_stale) begin
                m_stale = 1'b0;
                if (!st) m_ifv = 1'b0;
            end else begin
                f    = make_fetch(m_pc, rd);
                m_pc = f.next;
                if (m_ifv && st) begin
                    m_skid.push_back(f);
                end else begin
                    m_ifid = f;
                    m_ifv  = 1'b1;
                end
            end
        end else if (!st) begin
            m_ifv = 1'b0;
        end
    endtask

    task automatic compare_model();
        check_eq("imem_req", imem_req, m_req());
        check_eq("imem_addr", imem_addr, m_addr());
        check_eq("if_valid", if_valid, m_ifv);
        check_eq("if_pc", if_pc, m_ifid.pc);
        check_eq("if_inst", if_inst, m_ifid.inst);
        check_eq("if_next_pc", if_next_pc, m_ifid.next);
        check_eq("if_pred_taken", if_pred_taken, m_ifid.pred);
    endtask

    // ---------------- memory + cycle driver ----------------
    bit mem_busy;
    int mem_cnt;
    int fixed_lat;
    bit rand_lat;

    // called at a falling edge; checks, drives one cycle of inputs, steps the model
    task automatic cycle(input bit st, input bit fl, input logic [31:0] pr);
        bit          v;
        logic [31:0] rd;
        compare_model();
        stall    = st;
        flush    = fl;
        pc_right = pr;
        v        = 1'b0;
        rd       = 32'h0;
        if (imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_cnt  = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
            end
            if (mem_cnt == 0) begin
                v        = 1'b1;
                rd       = mem_word(imem_addr);
                mem_busy = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        imem_valid = v;
        imem_rdata = v ? rd : $urandom;
        @(posedge clk);
        model_step(st, fl, pr, v, rd);
        @(negedge clk);
    endtask

    // asynchronous reset asserted between edges; outputs must drop at once
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_req", imem_req, 32'h0);
        check_eq("rst_addr", imem_addr, RST_PC);
        check_eq("rst_if_valid", if_valid, 32'h0);
        check_eq("rst_if_pc", if_pc, 32'h0);
        check_eq("rst_if_inst", if_inst, 32'h13);
        check_eq("rst_if_next_pc", if_next_pc, 32'h0);
        check_eq("rst_if_pred", if_pred_taken, 32'h0);
        imem_valid = 1'b0;
        mem_busy   = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [31:0] jal_next_exp;
    logic        jal_pred_exp;

    initial begin
`ifdef FETCH_PRED_JAL_EN
        jal_next_exp = 32'h60;
        jal_pred_exp = 1'b1;
`else
        jal_next_exp = 32'h24;
        jal_pred_exp = 1'b0;
`endif
        rst_n      = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        pc_right   = 32'h0;
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        mem_busy   = 1'b0;
        mem_cnt    = 0;
        fixed_lat  = 0;
        rand_lat   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // straight-line fetch 0x0, 0x4, 0x8
        cycle(0, 0, 0);
        check_eq("first_req", imem_req, 32'h1);
        check_eq("first_addr", imem_addr, 32'h0);
        cycle(0, 0, 0);
        check_eq("pc0_if_pc", if_pc, 32'h0);
        check_eq("pc0_addr", imem_addr, 32'h4);
        cycle(0, 0, 0);
        check_eq("pc4_if_pc", if_pc, 32'h4);
        check_eq("pc4_next", if_next_pc, 32'h8);
        check_eq("pc4_addr", imem_addr, 32'h8);

        // stall 3 cycles while 0x8 returns -> skid
        cycle(1, 0, 0);
        check_eq("skid_req", imem_req, 32'h0);
        check_eq("skid_if_pc", if_pc, 32'h4);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        check_eq("unskid_if_pc", if_pc, 32'h8);
        check_eq("unskid_addr", imem_addr, 32'hC);

        // flush while 0x10 is still pending
        cycle(0, 0, 0);
        fixed_lat = 3;
        cycle(0, 0, 0);
        cycle(0, 1, 32'h100);
        check_eq("drop_if_valid", if_valid, 32'h0);
        check_eq("drop_addr_hold", imem_addr, 32'h10);
        fixed_lat = 0;
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check_eq("redir_addr", imem_addr, 32'h100);
        check_eq("redir_if_valid", if_valid, 32'h0);

        // flush together with stall while the skid is full
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        check_eq("full_req", imem_req, 32'h0);
        cycle(1, 1, 32'h200);
        check_eq("fs_if_valid", if_valid, 32'h0);
        check_eq("fs_addr", imem_addr, 32'h200);
        cycle(0, 0, 0);
        check_eq("fs_if_pc", if_pc, 32'h200);

        // wrap-around and unaligned redirect, coinciding with a response
        cycle(0, 1, 32'hFFFF_FFFF);
        check_eq("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        cycle(0, 0, 0);
        check_eq("wrap_next", if_next_pc, 32'h0);
        check_eq("wrap_addr0", imem_addr, 32'h0);

        // JAL at 0x20
        cycle(0, 1, 32'h20);
        cycle(0, 0, 0);
        check_eq("jal_if_pc", if_pc, 32'h20);
        check_eq("jal_next", if_next_pc, jal_next_exp);
        check_eq("jal_pred", if_pred_taken, jal_pred_exp);
        check_eq("jal_addr", imem_addr, jal_next_exp);

        // reset in the middle of a pending transaction
        fixed_lat = 3;
        cycle(0, 0, 0);
        mid_reset();
        fixed_lat = 0;
        cycle(0, 0, 0);
        check_eq("refetch_addr", imem_addr, RST_PC);

        // random traffic
        rand_lat = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            bit          st;
            bit          fl;
            logic [31:0] pr;
            st = ($urandom_range(0, 9) < 3);
            fl = ($urandom_range(0, 99) < 6);
            pr = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : 32'($urandom_range(0, 32'h3FF));
            if ($urandom_range(0, 499) == 0) mid_reset();
            else cycle(st, fl, pr);
        end
        cycle(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch stage: owns the program counter, issues single-outstanding requests to instruction memory, and loads the IF/ID pipeline register. It sits downstream of the branch-resolution mux and consumes that mux's `flush` / `pc_right` redirect. It also produces `if_next_pc`, the fall-through PC that the mux compares against the resolved target. A one-entry skid buffer absorbs a memory response that arrives while decode is stalled.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `clk  in  1`: rising-edge clock.
- `rst_n  in  1`: asynchronous, active-low reset.
- `stall  in  1`: hold the IF/ID register; from the hazard unit.
- `flush  in  1`: redirect request from branch resolution.
- `pc_right  in  32`: redirect target; valid only when `flush`=1.
- `imem_req  out  1`: fetch request.
- `imem_addr  out  32`: fetch address; word-aligned.
- `imem_valid  in  1`: response strobe; ends the current transaction.
- `imem_rdata  in  32`: instruction; valid with `imem_valid`.
- `if_valid  out  1`: IF/ID holds a live instruction.
- `if_pc  out  32`: PC of the IF/ID instruction.
- `if_inst  out  32`: IF/ID instruction.
- `if_next_pc  out  32`: PC the unit fetched (or will fetch) after `if_pc`.
- `if_pred_taken  out  1`: `if_next_pc` came from JAL prediction.

## Operation
- States: `IDLE`, `WAIT`, `FULL`.
- Registers:
  - `pc_q`: next fetch address.
  - `drop_q`: discard the in-flight response.
  - `skid_q` / `skid_pc_q` / `skid_next_q`: skid buffer.
- Reset values: state=`IDLE`, `pc_q`=`RESET_PC`, `drop_q`=0, `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_pc`=0, `if_inst`=`32'h0000_0013` (NOP), `if_next_pc`=0, `if_pred_taken`=0.
- `IDLE` → `WAIT` unconditionally.
- `WAIT`: `imem_req`=1 and `imem_addr`=`pc_q`. Both stay stable until `imem_valid`. A request is never retracted.
- Response in `WAIT` with `drop_q`=1: data discarded, `drop_q` cleared, stay in `WAIT` with the new `pc_q`.
- Response in `WAIT` with IF/ID free (`!if_valid || !stall`): IF/ID ← {`pc_q`, rdata, next}, `pc_q` ← next, stay in `WAIT`.
- Response in `WAIT` with IF/ID held: skid ← {`pc_q`, rdata, next}, `pc_q` ← next, go to `FULL`, `imem_req`=0.
- Default next = `pc_q + 4`, modulo 2^32; `32'hFFFF_FFFC` wraps to 0.
- `FULL`: when `stall`=0, IF/ID ← skid and go to `WAIT`.
- `stall`=1 with no response: IF/ID unchanged.
- `flush`=1 (priority over stall and over any response):
  - `if_valid` ← 0, skid cleared, `pc_q` ← `{pc_right[31:2],2'b00}`.
  - In `WAIT` with a transaction pending and no `imem_valid` this cycle: `drop_q` ← 1.
  - If `imem_valid` arrives in the same cycle as `flush`: that response is discarded directly and `drop_q` stays 0.
  - In `FULL`: state → `WAIT`.
- Reset mid-transaction: everything returns to reset values immediately. The memory must abandon the request when `rst_n`=0.

## Timing
- First `imem_req` one cycle after `rst_n` deasserts.
- IF/ID updates on the edge that samples `imem_valid`, so outputs are valid the cycle after the response.
- The next address is presented the cycle after `imem_valid`. `imem_req` may stay high across back-to-back transactions.
- Flush → redirected address on `imem_addr`:
  - Next cycle if idle or the response coincides with the flush.
  - Otherwise the cycle after the stale response.
- No combinational path from `imem_rdata` to `imem_addr`.

## Configuration
- `FETCH_PRED_JAL_EN` defined: when the instruction being loaded (IF/ID or skid) has opcode `7'b1101111`:
  - next = `pc_q + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0})`.
  - The accompanying `if_pred_taken` = 1.
  - Resolution then sees `pc_branch == if_next_pc`, and no flush is needed.
- Not defined: next is always `pc_q + 4`, and `if_pred_taken` is tied 0.

## Test plan
- Reset release, memory with 1-cycle response, instructions 0x13/0x13 → `imem_addr` sequence 0x0, 0x4, 0x8; IF/ID shows `if_pc`=0x0 then 0x4, with `if_next_pc`=`if_pc`+4.
- `stall` held 3 cycles while a response for 0x8 arrives → `FULL`, `imem_req`=0, IF/ID keeps 0x4; after stall drops, `if_pc`=0x8 and the fetch of 0xC follows.
- `flush` with `pc_right`=0x100 while a request to 0x10 is pending 2 more cycles → 0x10 data discarded, `if_valid`=0, next `imem_addr`=0x100.
- `flush` and `stall` in the same cycle, with the skid full → `if_valid`=0, skid empty, next fetch at `pc_right`.
- `rst_n` pulsed low mid-`WAIT` → all outputs at reset values asynchronously; refetch starts at `RESET_PC`.
- With `FETCH_PRED_JAL_EN`, JAL imm=+0x40 fetched at 0x20 → `if_next_pc`=0x60, `if_pred_taken`=1, next `imem_addr`=0x60. Without the macro → `if_next_pc`=0x24, `if_pred_taken`=0.
